// File: rtl/spi_bridge.sv
// SPI mode-0 slave that turns two-byte command/data frames into single-cycle
// read/write strobes on the PWM register bus, returning read data on MISO.
module spi_bridge (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       read,
  output logic       write,
  output logic [5:0] addr,
  output logic [7:0] data_write,
  input  logic [7:0] data_read
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    RD_REQ   = 3'd2,
    RD_CAP   = 3'd3,
    DATA     = 3'd4,
    WR_ISSUE = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic       sclk_p0, sclk_p1, sclk_p2;
  logic       cs_p0, cs_p1;
  logic       mosi_p0, mosi_p1;
  logic       settle_p0, settle_p1;
  logic       armed;

  logic       rise;
  logic       fall;
  logic       abort;
  logic [4:0] cnt;
  logic [7:0] rx_sr;
  logic [7:0] rx_next;
  logic [7:0] tx_sr;
  logic       rw;
  logic       cmd_done;
  logic       data_done;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= 5'd16) ? 5'd16 : v + 5'd1;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: sclk history for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0   <= 1'b0;
      sclk_p1   <= 1'b0;
      sclk_p2   <= 1'b0;
      cs_p0     <= 1'b1;
      cs_p1     <= 1'b1;
      mosi_p0   <= 1'b0;
      mosi_p1   <= 1'b0;
      settle_p0 <= 1'b0;
      settle_p1 <= 1'b0;
    end else begin
      sclk_p0   <= sclk;
      sclk_p1   <= sclk_p0;
      sclk_p2   <= sclk_p1;
      cs_p0     <= cs_n;
      cs_p1     <= cs_p0;
      mosi_p0   <= mosi;
      mosi_p1   <= mosi_p0;
      settle_p0 <= 1'b1;
      settle_p1 <= settle_p0;
    end
  end

  assign rise      = sclk_p1 & ~sclk_p2;
  assign fall      = ~sclk_p1 & sclk_p2;
  assign abort     = cs_p1;
  assign rx_next   = {rx_sr[6:0], mosi_p1};
  assign cmd_done  = rise && (cnt == 5'd7);
  assign data_done = rise && (cnt == 5'd15);

  // A frame may only start after cs_n has been seen high through a flushed
  // synchroniser, so a reset in the middle of a frame never resumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (settle_p1 && cs_p1) begin
      armed <= 1'b1;
    end else if (state_nx == CMD && state == IDLE) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (armed && !cs_p1) state_nx = CMD;
      CMD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cmd_done) begin
          state_nx = rx_next[7] ? DATA : RD_REQ;
        end
      end
      RD_REQ:   state_nx = abort ? IDLE : RD_CAP;
      RD_CAP:   state_nx = abort ? IDLE : DATA;
      DATA: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (data_done) begin
          state_nx = rw ? WR_ISSUE : DONE;
        end
      end
      WR_ISSUE: state_nx = DONE;
      DONE:     if (cs_p1) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    read  = (state == RD_REQ);
    write = (state == WR_ISSUE);
    miso  = 1'b0;
    if (state == RD_CAP) begin
      miso = data_read[7];
    end else if (state == DATA && !rw) begin
      miso = tx_sr[7];
    end
  end

  // Stage p2 -> datapath: bit counter, shift registers and bus-side latches
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 5'd0;
      rx_sr      <= 8'd0;
      tx_sr      <= 8'd0;
      rw         <= 1'b0;
      addr       <= 6'd0;
      data_write <= 8'd0;
    end else begin
      if (state == IDLE) begin
        cnt <= 5'd0;
      end else if (rise) begin
        cnt <= sat_inc(cnt);
      end

      if ((state == CMD || state == DATA) && rise && cnt < 5'd16) begin
        rx_sr <= rx_next;
      end

      if (state == CMD && !abort && cmd_done) begin
        addr <= rx_next[5:0];
        rw   <= rx_next[7];
      end

      if (state == DATA && !abort && data_done && rw) begin
        data_write <= rx_next;
      end

      // Read data leaves MSB first; bit 7 is already on miso for the 9th rise.
      if (state == IDLE) begin
        tx_sr <= 8'd0;
      end else if (state == RD_CAP) begin
        tx_sr <= data_read;
      end else if (state == DATA && !rw && fall && cnt >= 5'd9) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_bridge.sv
// Randomised scoreboard bench for spi_bridge: an SPI master task issues frames
// and queues the expected bus strobes; a monitor pops and compares them.
module tb_spi_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  typedef struct packed {
    logic       is_wr;
    logic [5:0] a;
    logic [7:0] d;
  } strobe_t;

  strobe_t    exp_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] regs[64];
  logic [7:0] ref_mem[64];
  strobe_t    mon_e;
  logic       prev_strobe = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  spi_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read)
  );

  function automatic logic [7:0] init_val(input int i);
    logic [31:0] v;
    v = i * 37 + 11;
    return (i == 13) ? 8'h3C : v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Register file: data_read valid exactly one clk after read, zero otherwise
  always @(posedge clk) begin
    if (rst) begin
      data_read <= 8'h00;
      if (checks == 0) begin
        for (int i = 0; i < 64; i++) regs[i] <= init_val(i);
      end
    end else begin
      data_read <= read ? regs[addr] : 8'h00;
      if (write) regs[addr] <= data_write;
    end
  end

  // Monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst) begin
      if (read && write) check("rd_wr_overlap", 32'd1, 32'd0);
      if (read || write) begin
        if (prev_strobe) check("strobe_one_cycle", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, read, write}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {31'd0, write}, {31'd0, mon_e.is_wr});
          check("addr", {26'd0, addr}, {26'd0, mon_e.a});
          if (mon_e.is_wr) check("data_write", {24'd0, data_write}, {24'd0, mon_e.d});
        end
      end
      prev_strobe <= read | write;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_read"}, {31'd0, read}, 32'd0);
    check({tag, "_write"}, {31'd0, write}, 32'd0);
    check({tag, "_addr"}, {26'd0, addr}, 32'd0);
    check({tag, "_data_write"}, {24'd0, data_write}, 32'd0);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
  endtask

  // abort_at: raise cs_n after that many rises; rst_at: pulse rst after that many
  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int npulses,
                       input int abort_at, input int rst_at, input int gap);
    logic [15:0] bits;
    logic [7:0]  rx;
    logic [5:0]  a;
    logic [7:0]  exp_rd;
    int          n_eff;
    bit          complete;
    bits     = {cmd, dat};
    rx       = 8'h00;
    a        = cmd[5:0];
    n_eff    = npulses;
    if (abort_at != 0) n_eff = abort_at;
    if (rst_at != 0) n_eff = rst_at;
    complete = (n_eff >= 16);
    exp_rd   = ref_mem[a];
    if (cmd[7]) begin
      if (complete) begin
        exp_q.push_back(strobe_t'({1'b1, a, dat}));
        ref_mem[a] = dat;
      end
    end else begin
      if (n_eff >= 8) exp_q.push_back(strobe_t'({1'b0, a, 8'h00}));
      if (complete) miso_q.push_back(exp_rd);
    end

    @(negedge clk);
    cs_n = 1'b0;
    sclk = 1'b0;
    mosi = bits[15];
    repeat (6) @(negedge clk);
    for (int i = 0; i < npulses; i++) begin
      if (abort_at != 0 && i == abort_at) break;
      sclk = 1'b1;
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      repeat (6) @(negedge clk);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? bits[14 - i] : 1'($urandom);
      if (rst_at != 0 && i + 1 == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
      end
      repeat (6) @(negedge clk);
    end
    if (complete || cmd[7]) check("miso_after_frame", {31'd0, miso}, 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
    if (complete && !cmd[7]) begin
      if (miso_q.size() == 0) begin
        check("miso_queue_empty", 32'd1, 32'd0);
      end else begin
        check("miso_byte", {24'd0, rx}, {24'd0, miso_q.pop_front()});
      end
    end
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] d;
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    frame(8'h80, 8'hA5, 16, 0, 0, 6);
    frame(8'h0D, 8'h00, 16, 0, 0, 6);
    frame(8'h83, 8'h5A, 16, 12, 0, 6);
    frame(8'h85, 8'h11, 16, 0, 0, 6);
    frame(8'h9E, 8'h77, 16, 0, 11, 6);
    frame(8'h81, 8'h42, 16, 0, 0, 6);
    frame(8'h8A, 8'h07, 20, 0, 0, 6);
    frame(8'h08, 8'h00, 16, 0, 0, 4);
    frame(8'h8C, 8'h01, 16, 0, 0, 4);
    frame(8'h0C, 8'h00, 16, 0, 0, 4);

    for (int k = 0; k < 14; k++) begin
      c = 8'($urandom);
      d = 8'($urandom);
      frame(c, d, 16, 0, 0, $urandom_range(4, 8));
    end

    repeat (20) @(negedge clk);
    check("pending_strobes", exp_q.size(), 32'd0);
    check("pending_miso", miso_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
